// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared types and defaults for the AHB-to-APB bridge
package bridge_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int SEL_W_DEF  = 3;

    localparam logic [SEL_W_DEF-1:0] SEL_NONE = '0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_t;

endpackage

// File: rtl/apb_controller.sv
// rtl/apb_controller.sv - APB master state machine of the AHB-to-APB bridge
module apb_controller
    import bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              valid,
    input  logic              hwrite,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [SEL_W-1:0]  temp_selx,
    output logic              pwrite,
    output logic              penable,
    output logic [SEL_W-1:0]  pselx,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hreadyout
);

    state_t             r_state;
    state_t             w_next;
    logic               w_acc;
    logic [ADDR_W-1:0]  r_pend_addr;
    logic               r_pend_write;
    logic [SEL_W-1:0]   r_pend_sel;
    logic [DATA_W-1:0]  r_pend_wdata;
    logic               r_wr_dphase;

    assign w_acc = valid & hreadyout;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (w_acc) w_next = hwrite ? ST_WWAIT : ST_READ;
                else       w_next = ST_IDLE;
            end
            ST_WWAIT:    w_next = w_acc ? ST_WRITEP : ST_WRITE;
            ST_READ:     w_next = ST_RENABLE;
            ST_WRITE:    w_next = ST_WENABLE;
            ST_WRITEP:   w_next = ST_WENABLEP;
            ST_WENABLEP: w_next = r_pend_write ? ST_WRITE : ST_READ;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state      <= ST_IDLE;
            pwrite       <= 1'b0;
            penable      <= 1'b0;
            pselx        <= '0;
            paddr        <= '0;
            pwdata       <= '0;
            hreadyout    <= 1'b1;
            r_pend_addr  <= '0;
            r_pend_write <= 1'b0;
            r_pend_sel   <= '0;
            r_pend_wdata <= '0;
            r_wr_dphase  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_pend_addr  <= haddr;
                r_pend_write <= hwrite;
                r_pend_sel   <= temp_selx;
            end
            // write data trails its address phase by one cycle
            r_wr_dphase <= w_acc & hwrite;
            if (r_wr_dphase) r_pend_wdata <= hwdata;
            hreadyout <= (w_next == ST_IDLE)    || (w_next == ST_WWAIT) ||
                         (w_next == ST_RENABLE) || (w_next == ST_WENABLE);
            case (w_next)
                ST_READ: begin
                    penable <= 1'b0;
                    pwrite  <= 1'b0;
                    if (r_state == ST_WENABLEP) begin
                        pselx <= r_pend_sel;
                        paddr <= r_pend_addr;
                    end else begin
                        pselx <= temp_selx;
                        paddr <= haddr;
                    end
                end
                ST_WRITE, ST_WRITEP: begin
                    penable <= 1'b0;
                    pwrite  <= 1'b1;
                    pselx   <= r_pend_sel;
                    paddr   <= r_pend_addr;
                    // from WWAIT the first write's data is still on the bus
                    pwdata  <= (r_state == ST_WWAIT) ? hwdata : r_pend_wdata;
                end
                ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                    penable <= 1'b1;
                end
                default: begin
                    pselx   <= SEL_W'(SEL_NONE);
                    penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_controller.sv
// tb/tb_apb_controller.sv - scoreboard bench for apb_controller
module tb_apb_controller;

    logic        hclk;
    logic        hreset;
    logic        valid;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [2:0]  temp_selx;
    logic        pwrite;
    logic        penable;
    logic [2:0]  pselx;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hreadyout;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t exp_q[$];
    int    checks;
    int    errors;
    int    n_push;
    int    n_enable;

    apb_controller #(.ADDR_W(32), .DATA_W(32), .SEL_W(3)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .valid     (valid),
        .hwrite    (hwrite),
        .haddr     (haddr),
        .hwdata    (hwdata),
        .temp_selx (temp_selx),
        .pwrite    (pwrite),
        .penable   (penable),
        .pselx     (pselx),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .hreadyout (hreadyout)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_in();
        valid     = 1'b0;
        hwrite    = 1'b0;
        haddr     = '0;
        temp_selx = '0;
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [2:0] s);
        valid     = 1'b1;
        hwrite    = w;
        haddr     = a;
        temp_selx = s;
    endtask

    task automatic push(input logic [2:0] s, input logic [31:0] a, input logic w, input logic [31:0] d);
        xfer_t x;
        x.sel   = s;
        x.addr  = a;
        x.wr    = w;
        x.wdata = d;
        exp_q.push_back(x);
        n_push++;
    endtask

    // Monitor: every APB enable cycle must match the oldest expected transfer
    always @(negedge hclk) begin
        if (!hreset && penable && pselx != 3'b000) begin
            xfer_t e;
            n_enable++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_apb actual addr=%0h required none", paddr);
            end else begin
                e = exp_q.pop_front();
                chk("apb_sel",   64'(pselx),  64'(e.sel));
                chk("apb_addr",  64'(paddr),  64'(e.addr));
                chk("apb_write", 64'(pwrite), 64'(e.wr));
                chk("apb_wdata", 64'(pwdata), 64'(e.wdata));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; n_push = 0; n_enable = 0;
        hreset = 1'b1;
        hwdata = '0;
        idle_in();
        repeat (2) step();
        chk("rst_pselx",   64'(pselx),     64'h0);
        chk("rst_penable", 64'(penable),   64'h0);
        chk("rst_pwrite",  64'(pwrite),    64'h0);
        chk("rst_paddr",   64'(paddr),     64'h0);
        chk("rst_pwdata",  64'(pwdata),    64'h0);
        chk("rst_hready",  64'(hreadyout), 64'h1);
        hreset = 1'b0;
        step();

        // single read
        req(1'b0, 32'h8000_0010, 3'b001);
        push(3'b001, 32'h8000_0010, 1'b0, 32'h0);
        step();
        idle_in();
        chk("rd_setup_sel",    64'(pselx),     64'h1);
        chk("rd_setup_addr",   64'(paddr),     64'h8000_0010);
        chk("rd_setup_pen",    64'(penable),   64'h0);
        chk("rd_setup_hready", 64'(hreadyout), 64'h0);
        step();
        chk("rd_en_pen",    64'(penable),   64'h1);
        chk("rd_en_hready", 64'(hreadyout), 64'h1);
        step();
        chk("rd_done_sel", 64'(pselx),   64'h0);
        chk("rd_done_pen", 64'(penable), 64'h0);

        // single write
        req(1'b1, 32'h8400_0004, 3'b010);
        step();
        idle_in();
        hwdata = 32'hDEAD_BEEF;
        push(3'b010, 32'h8400_0004, 1'b1, 32'hDEAD_BEEF);
        chk("wwait_hready", 64'(hreadyout), 64'h1);
        chk("wwait_sel",    64'(pselx),     64'h0);
        step();
        chk("wr_setup_wdata",  64'(pwdata),    64'hDEAD_BEEF);
        chk("wr_setup_pwrite", 64'(pwrite),    64'h1);
        chk("wr_setup_pen",    64'(penable),   64'h0);
        chk("wr_setup_sel",    64'(pselx),     64'h2);
        chk("wr_setup_hready", 64'(hreadyout), 64'h0);
        hwdata = '0;
        step();
        chk("wr_en_pen",    64'(penable),   64'h1);
        chk("wr_en_hready", 64'(hreadyout), 64'h1);
        step();
        chk("wr_done_sel", 64'(pselx), 64'h0);

        // write then pipelined read
        req(1'b1, 32'h8000_0000, 3'b001);
        step();
        hwdata = 32'h1111_2222;
        req(1'b0, 32'h8000_0008, 3'b001);
        push(3'b001, 32'h8000_0000, 1'b1, 32'h1111_2222);
        push(3'b001, 32'h8000_0008, 1'b0, 32'h1111_2222);
        step();
        idle_in();
        chk("wp_addr",   64'(paddr),     64'h8000_0000);
        chk("wp_pwrite", 64'(pwrite),    64'h1);
        chk("wp_wdata",  64'(pwdata),    64'h1111_2222);
        chk("wp_hready", 64'(hreadyout), 64'h0);
        step();
        chk("wep_pen",    64'(penable),   64'h1);
        chk("wep_hready", 64'(hreadyout), 64'h0);
        step();
        chk("prd_addr",   64'(paddr),     64'h8000_0008);
        chk("prd_pwrite", 64'(pwrite),    64'h0);
        chk("prd_pen",    64'(penable),   64'h0);
        chk("prd_sel",    64'(pselx),     64'h1);
        chk("prd_hready", 64'(hreadyout), 64'h0);
        step();
        chk("pre_pen",    64'(penable),   64'h1);
        chk("pre_hready", 64'(hreadyout), 64'h1);
        step();

        // back-to-back writes
        req(1'b1, 32'h8800_0000, 3'b100);
        step();
        hwdata = 32'hAAAA_0001;
        req(1'b1, 32'h8800_0004, 3'b100);
        push(3'b100, 32'h8800_0000, 1'b1, 32'hAAAA_0001);
        push(3'b100, 32'h8800_0004, 1'b1, 32'hBBBB_0002);
        step();
        idle_in();
        hwdata = 32'hBBBB_0002;
        chk("b2b_w1_wdata", 64'(pwdata),  64'hAAAA_0001);
        chk("b2b_w1_addr",  64'(paddr),   64'h8800_0000);
        chk("b2b_w1_pen",   64'(penable), 64'h0);
        step();
        hwdata = '0;
        chk("b2b_en1_pen", 64'(penable), 64'h1);
        step();
        chk("b2b_w2_pen",   64'(penable), 64'h0);
        chk("b2b_w2_wdata", 64'(pwdata),  64'hBBBB_0002);
        chk("b2b_w2_addr",  64'(paddr),   64'h8800_0004);
        chk("b2b_w2_sel",   64'(pselx),   64'h4);
        step();
        chk("b2b_en2_pen",    64'(penable),   64'h1);
        chk("b2b_en2_hready", 64'(hreadyout), 64'h1);
        step();

        // valid held while stalled must not start a second transfer
        req(1'b0, 32'h8000_0030, 3'b001);
        push(3'b001, 32'h8000_0030, 1'b0, 32'hBBBB_0002);
        step();
        req(1'b0, 32'h8000_0020, 3'b010);
        chk("hold_hready", 64'(hreadyout), 64'h0);
        step();
        idle_in();
        chk("hold_addr", 64'(paddr),   64'h8000_0030);
        chk("hold_pen",  64'(penable), 64'h1);
        step();
        chk("hold_done_sel", 64'(pselx), 64'h0);
        step();
        chk("hold_xfer_count", 64'(n_enable), 64'(n_push));

        // reset in the middle of an enable cycle
        req(1'b0, 32'h8000_0040, 3'b001);
        step();
        idle_in();
        step();
        chk("pre_rst_pen", 64'(penable), 64'h1);
        #1;
        hreset = 1'b1;
        #1;
        chk("arst_pen",    64'(penable),   64'h0);
        chk("arst_sel",    64'(pselx),     64'h0);
        chk("arst_addr",   64'(paddr),     64'h0);
        chk("arst_pwdata", 64'(pwdata),    64'h0);
        chk("arst_hready", 64'(hreadyout), 64'h1);
        step();
        hreset = 1'b0;
        step();
        chk("post_rst_hready", 64'(hreadyout), 64'h1);
        chk("post_rst_sel",    64'(pselx),     64'h0);
        req(1'b0, 32'h8000_0050, 3'b001);
        push(3'b001, 32'h8000_0050, 1'b0, 32'h0);
        step();
        idle_in();
        chk("post_rst_rd_addr",   64'(paddr),     64'h8000_0050);
        chk("post_rst_rd_hready", 64'(hreadyout), 64'h0);
        repeat (3) step();

        chk("queue_empty",  64'(exp_q.size()), 64'h0);
        chk("xfer_count",   64'(n_enable),     64'(n_push));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
